// File: rtl/operand_fetch_stage.sv
// ID-stage operand resolution: EX/MEM forwarding, X31 zeroing, load-use
// hazard detection, and the ID/EX pipeline register with a stall counter.
module operand_fetch_stage #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic [4:0]       id_rd,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             id_use_imm,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [WIDTH-1:0] rf_data1,
    input  logic [WIDTH-1:0] rf_data2,
    input  logic             fwd_ex_en,
    input  logic [4:0]       fwd_ex_rd,
    input  logic [WIDTH-1:0] fwd_ex_data,
    input  logic             fwd_mem_en,
    input  logic [4:0]       fwd_mem_rd,
    input  logic [WIDTH-1:0] fwd_mem_data,
    input  logic             flush,
    input  logic             ex_hold,
    output logic             stall,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_is_load,
    output logic [4:0]       ex_rd,
    output logic [WIDTH-1:0] ex_op_a,
    output logic [WIDTH-1:0] ex_op_b,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [4:0] ZERO_REG = 5'd31;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] op_b;
    logic             ex_match;

    // Priority: zero register, then the younger EX result, then MEM, then RF.
    function automatic logic [WIDTH-1:0] fwd_sel(
        input logic [4:0]       src,
        input logic [WIDTH-1:0] rf,
        input logic             ex_en,
        input logic [4:0]       ex_rd_f,
        input logic [WIDTH-1:0] ex_data,
        input logic             mem_en,
        input logic [4:0]       mem_rd_f,
        input logic [WIDTH-1:0] mem_data
    );
        logic [WIDTH-1:0] res;
        if (src == ZERO_REG)
            res = '0;
        else if (ex_en && ex_rd_f != ZERO_REG && ex_rd_f == src)
            res = ex_data;
        else if (mem_en && mem_rd_f != ZERO_REG && mem_rd_f == src)
            res = mem_data;
        else
            res = rf;
        return res;
    endfunction

    always_comb begin
        src_a = fwd_sel(id_rn, rf_data1, fwd_ex_en, fwd_ex_rd, fwd_ex_data,
                        fwd_mem_en, fwd_mem_rd, fwd_mem_data);
        src_b = fwd_sel(id_rm, rf_data2, fwd_ex_en, fwd_ex_rd, fwd_ex_data,
                        fwd_mem_en, fwd_mem_rd, fwd_mem_data);
        op_b  = id_use_imm ? id_imm : src_b;
    end

    // Load-use hazard; a flush squashes the consumer so no bubble is needed.
    always_comb begin
        ex_match = (id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd);
        stall    = id_valid && ex_valid && ex_is_load && (ex_rd != ZERO_REG)
                   && ex_match && !flush;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_is_load    <= 1'b0;
            ex_rd         <= ZERO_REG;
            ex_op_a       <= '0;
            ex_op_b       <= '0;
            ex_store_data <= '0;
            stall_count   <= '0;
        end else if (ex_hold) begin
            ex_valid      <= ex_valid;
        end else if (flush || stall) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_is_load    <= 1'b0;
            ex_rd         <= ZERO_REG;
            ex_op_a       <= '0;
            ex_op_b       <= '0;
            ex_store_data <= '0;
            if (stall && stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + CNT_W'(1);
        end else begin
            ex_valid      <= id_valid;
            ex_reg_write  <= id_reg_write && id_valid;
            ex_is_load    <= id_is_load;
            ex_rd         <= id_rd;
            ex_op_a       <= src_a;
            ex_op_b       <= op_b;
            ex_store_data <= src_b;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed self-checking bench for operand_fetch_stage.
module tb_operand_fetch_stage;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_use_rn, id_use_rm, id_reg_write, id_is_load, id_use_imm;
    logic [4:0]       id_rn, id_rm, id_rd;
    logic [WIDTH-1:0] id_imm, rf_data1, rf_data2;
    logic             fwd_ex_en, fwd_mem_en;
    logic [4:0]       fwd_ex_rd, fwd_mem_rd;
    logic [WIDTH-1:0] fwd_ex_data, fwd_mem_data;
    logic             flush, ex_hold;
    logic             stall, ex_valid, ex_reg_write, ex_is_load;
    logic [4:0]       ex_rd;
    logic [WIDTH-1:0] ex_op_a, ex_op_b, ex_store_data;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int failures = 0;

    operand_fetch_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .id_use_imm(id_use_imm), .id_imm(id_imm),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .fwd_ex_en(fwd_ex_en), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .flush(flush), .ex_hold(ex_hold), .stall(stall),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_store_data(ex_store_data), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                             input logic use_rn, input logic use_rm, input logic is_load);
        id_valid     = 1'b1;
        id_rn        = rn;
        id_rm        = rm;
        id_rd        = rd;
        id_use_rn    = use_rn;
        id_use_rm    = use_rm;
        id_reg_write = 1'b1;
        id_is_load   = is_load;
        id_use_imm   = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        id_valid = 0; id_rn = 0; id_rm = 0; id_rd = 0;
        id_use_rn = 0; id_use_rm = 0; id_reg_write = 0; id_is_load = 0;
        id_use_imm = 0; id_imm = 0; rf_data1 = 0; rf_data2 = 0;
        fwd_ex_en = 0; fwd_ex_rd = 0; fwd_ex_data = 0;
        fwd_mem_en = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
        flush = 0; ex_hold = 0;
        step(); step();

        check("rst_valid", 64'(ex_valid), 64'd0);
        check("rst_rd", 64'(ex_rd), 64'd31);
        check("rst_op_a", ex_op_a, 64'd0);
        check("rst_count", 64'(stall_count), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);

        // Plain RF operands
        rst = 1'b1;
        set_instr(5'd3, 5'd4, 5'd1, 1'b1, 1'b1, 1'b0);
        rf_data1 = 64'h11; rf_data2 = 64'h22;
        step();
        check("rf_op_a", ex_op_a, 64'h11);
        check("rf_op_b", ex_op_b, 64'h22);
        check("rf_store", ex_store_data, 64'h22);
        check("rf_valid", 64'(ex_valid), 64'd1);
        check("rf_regwr", 64'(ex_reg_write), 64'd1);
        check("rf_rd", 64'(ex_rd), 64'd1);

        // EX beats MEM
        fwd_ex_en = 1; fwd_ex_rd = 5'd3; fwd_ex_data = 64'hAAAA;
        fwd_mem_en = 1; fwd_mem_rd = 5'd3; fwd_mem_data = 64'hBBBB;
        step();
        check("fwd_ex_prio", ex_op_a, 64'hAAAA);
        check("fwd_none_b", ex_op_b, 64'h22);

        fwd_ex_en = 0;
        step();
        check("fwd_mem", ex_op_a, 64'hBBBB);

        // Immediate on B while store data still forwards rm
        fwd_ex_en = 1;
        fwd_mem_rd = 5'd4; fwd_mem_data = 64'hCCCC;
        id_use_imm = 1; id_imm = 64'h5555;
        step();
        check("imm_op_a", ex_op_a, 64'hAAAA);
        check("imm_op_b", ex_op_b, 64'h5555);
        check("imm_store", ex_store_data, 64'hCCCC);

        // Zero register
        id_use_imm = 0;
        id_rn = 5'd31; id_rm = 5'd31; rf_data1 = 64'h99;
        fwd_ex_rd = 5'd31; fwd_mem_rd = 5'd31;
        step();
        check("x31_op_a", ex_op_a, 64'd0);
        check("x31_store", ex_store_data, 64'd0);
        fwd_ex_en = 0; fwd_mem_en = 0;

        // Load-use: one bubble, then consumer picks up MEM forward
        set_instr(5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        step();
        check("ld_is_load", 64'(ex_is_load), 64'd1);
        set_instr(5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0);
        rf_data1 = 64'h1234;
        #1 check("lu_stall", 64'(stall), 64'd1);
        step();
        check("lu_bubble", 64'(ex_valid), 64'd0);
        check("lu_bubble_rd", 64'(ex_rd), 64'd31);
        check("lu_count", 64'(stall_count), 64'd1);
        check("lu_stall_clr", 64'(stall), 64'd0);
        fwd_mem_en = 1; fwd_mem_rd = 5'd5; fwd_mem_data = 64'h77;
        step();
        check("lu_fwd_a", ex_op_a, 64'h77);
        check("lu_valid", 64'(ex_valid), 64'd1);
        check("lu_rd", 64'(ex_rd), 64'd7);
        fwd_mem_en = 0;

        // Flush beats load-use hazard
        set_instr(5'd2, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);
        step();
        set_instr(5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        #1 check("fl_stall_pre", 64'(stall), 64'd1);
        flush = 1;
        #1 check("fl_stall", 64'(stall), 64'd0);
        step();
        check("fl_valid", 64'(ex_valid), 64'd0);
        check("fl_count", 64'(stall_count), 64'd1);
        flush = 0;

        // Hold freezes ID/EX
        set_instr(5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0);
        rf_data1 = 64'h11;
        step();
        check("hd_pre", ex_op_a, 64'h11);
        ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            rf_data1 = 64'h100 + 64'(i);
            id_rd = 5'(10 + i);
            step();
            check("hd_op_a", ex_op_a, 64'h11);
            check("hd_rd", 64'(ex_rd), 64'd9);
        end
        ex_hold = 0;
        rf_data1 = 64'h200; id_rd = 5'd12;
        step();
        check("hd_rel_a", ex_op_a, 64'h200);
        check("hd_rel_rd", 64'(ex_rd), 64'd12);

        // Build stall_count up to 5
        for (int i = 0; i < 4; i++) begin
            set_instr(5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
            step();
            set_instr(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0);
            step();
        end
        check("cnt5", 64'(stall_count), 64'd5);

        // Hold during hazard does not count
        set_instr(5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        step();
        set_instr(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0);
        ex_hold = 1;
        step();
        check("hz_hold_stall", 64'(stall), 64'd1);
        check("hz_hold_cnt", 64'(stall_count), 64'd5);
        check("hz_hold_load", 64'(ex_is_load), 64'd1);

        // Reset wins over hold and stall
        rst = 0;
        step();
        check("mr_valid", 64'(ex_valid), 64'd0);
        check("mr_is_load", 64'(ex_is_load), 64'd0);
        check("mr_rd", 64'(ex_rd), 64'd31);
        check("mr_op_a", ex_op_a, 64'd0);
        check("mr_count", 64'(stall_count), 64'd0);
        check("mr_stall", 64'(stall), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
